// File: rtl/pet_needs_core_pkg.sv
// Shared definitions for the virtual-pet needs engine: need indices, level defaults,
// pet mode encoding and the 7-segment encoder.
package pet_needs_core_pkg;

   localparam int NEED_HEALTH = 0;
   localparam int NEED_ENERGY = 1;
   localparam int NEED_HUNGER = 2;
   localparam int NEED_FUN    = 3;

   localparam int DEF_MAX_LEVEL  = 10;
   localparam int DEF_INIT_LEVEL = 8;

   typedef enum logic [1:0] {
      ST_NORMAL = 2'd0,
      ST_TEST   = 2'd1,
      ST_DEAD   = 2'd2
   } pet_state_e;

   // gfedcba, active-high; 10 shows as 'A', anything above is blank
   function automatic logic [6:0] seg7_encode(input logic [7:0] val);
      logic [6:0] seg;
      case (val)
         8'd0:    seg = 7'b0111111;
         8'd1:    seg = 7'b0000110;
         8'd2:    seg = 7'b1011011;
         8'd3:    seg = 7'b1001111;
         8'd4:    seg = 7'b1100110;
         8'd5:    seg = 7'b1101101;
         8'd6:    seg = 7'b1111101;
         8'd7:    seg = 7'b0000111;
         8'd8:    seg = 7'b1111111;
         8'd9:    seg = 7'b1101111;
         8'd10:   seg = 7'b1110111;
         default: seg = 7'b0000000;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/pet_needs_core_if.sv
// Button inputs and display/status outputs of the needs engine.
interface pet_needs_core_if #(
   parameter int NUM_NEEDS = 4,
   parameter int LEVEL_W   = 4
);
   localparam int SEL_W = (NUM_NEEDS > 1) ? $clog2(NUM_NEEDS) : 1;

   logic [NUM_NEEDS-1:0]         btn_need;
   logic                         btn_reset;
   logic                         btn_test;
   logic [SEL_W-1:0]             sel_need;
   logic [LEVEL_W-1:0]           sel_level;
   logic [NUM_NEEDS*LEVEL_W-1:0] levels;
   logic                         happy;
   logic [6:0]                   seg7;
   logic                         test_mode;
   logic                         dead;
   logic                         sec_tick;

   modport master (
      output btn_need, btn_reset, btn_test,
      input  sel_need, sel_level, levels, happy, seg7, test_mode, dead, sec_tick
   );

   modport slave (
      input  btn_need, btn_reset, btn_test,
      output sel_need, sel_level, levels, happy, seg7, test_mode, dead, sec_tick
   );
endinterface

// File: rtl/pet_needs_core_long_press_det.sv
// Long-press detector: counts whole seconds a button is held and pulses once per hold.
module long_press_det #(
   parameter int LONG_PRESS_SEC = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   input  logic i_sec_tick,
   output logic o_fire
);
   localparam int CNT_W = $clog2(LONG_PRESS_SEC + 1);

   // Zero means spent or not yet armed; only a release reloads it, so a button
   // still held across rst_n or after firing cannot fire again.
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (!i_btn) begin
         r_cnt <= CNT_W'(LONG_PRESS_SEC);
      end else if (i_sec_tick && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_fire = i_btn & i_sec_tick & (r_cnt == CNT_W'(1));

endmodule

// File: rtl/pet_needs_core.sv
// Needs engine: per-need saturating levels with independent decay periods,
// button select/feed, long-press pet reset and test-mode toggle.
//
// state     | meaning
// ST_NORMAL | levels decay, feed adds one, a zero level kills the pet
// ST_TEST   | decay frozen, feed toggles selected level between 1 and MAX
// ST_DEAD   | need buttons, decay and test toggle ignored until long reset
module pet_needs_core
   import pet_needs_core_pkg::*;
#(
   parameter int                       NUM_NEEDS      = 4,
   parameter int                       LEVEL_W        = 4,
   parameter int                       MAX_LEVEL      = DEF_MAX_LEVEL,
   parameter int                       INIT_LEVEL     = DEF_INIT_LEVEL,
   parameter int                       HAPPY_MIN      = 5,
   parameter int                       CLK_PER_SEC    = 50_000_000,
   parameter int                       LONG_PRESS_SEC = 5,
   parameter logic [NUM_NEEDS*8-1:0]   DECAY_SEC      = {8'd50, 8'd70, 8'd100, 8'd120}
) (
   input  logic              clk,
   input  logic              rst_n,
   pet_needs_core_if.slave   bus
);
   localparam int SEL_W   = (NUM_NEEDS > 1) ? $clog2(NUM_NEEDS) : 1;
   localparam int PRESC_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

   localparam logic [LEVEL_W-1:0] L_MAX   = LEVEL_W'(MAX_LEVEL);
   localparam logic [LEVEL_W-1:0] L_INIT  = LEVEL_W'(INIT_LEVEL);
   localparam logic [LEVEL_W-1:0] L_HAPPY = LEVEL_W'(HAPPY_MIN);
   localparam logic [LEVEL_W-1:0] L_ONE   = LEVEL_W'(1);

   logic [PRESC_W-1:0]           r_presc;
   logic                         w_sec_tick;
   logic [NUM_NEEDS-1:0]         r_btn_q;
   logic [NUM_NEEDS-1:0]         w_rise;
   logic                         w_hit;
   logic [SEL_W-1:0]             w_hit_idx;
   logic [SEL_W-1:0]             r_sel_need;
   logic                         w_fire_reset;
   logic                         w_fire_test;
   logic                         w_pet_reset;
   logic                         w_test_toggle;
   pet_state_e                   r_state;
   pet_state_e                   w_state_nxt;
   logic                         w_normal;
   logic                         w_test;
   logic                         w_alive;
   logic                         w_press_sel;
   logic [NUM_NEEDS-1:0]         w_zero;
   logic                         w_any_zero;
   logic [LEVEL_W-1:0]           w_level_arr [NUM_NEEDS];
   logic [NUM_NEEDS*LEVEL_W-1:0] w_levels;
   logic [LEVEL_W-1:0]           w_sel_level;

   assign w_sec_tick = (r_presc == PRESC_W'(CLK_PER_SEC - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_presc <= '0;
      end else if (w_sec_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PRESC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_btn_q <= '0;
      end else begin
         r_btn_q <= bus.btn_need;
      end
   end

   assign w_rise = bus.btn_need & ~r_btn_q;

   // Walk downwards so the lowest rising index is the one left standing
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      for (int i = NUM_NEEDS - 1; i >= 0; i--) begin
         if (w_rise[i]) begin
            w_hit     = 1'b1;
            w_hit_idx = SEL_W'(i);
         end
      end
   end

   long_press_det #(.LONG_PRESS_SEC(LONG_PRESS_SEC)) u_lp_reset (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_btn      (bus.btn_reset),
      .i_sec_tick (w_sec_tick),
      .o_fire     (w_fire_reset)
   );

   long_press_det #(.LONG_PRESS_SEC(LONG_PRESS_SEC)) u_lp_test (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_btn      (bus.btn_test),
      .i_sec_tick (w_sec_tick),
      .o_fire     (w_fire_test)
   );

   assign w_pet_reset   = w_fire_reset;
   assign w_test_toggle = w_fire_test & ~w_fire_reset;

   assign w_normal    = (r_state == ST_NORMAL);
   assign w_test      = (r_state == ST_TEST);
   assign w_alive     = (r_state != ST_DEAD);
   assign w_press_sel = w_hit & w_alive & (w_hit_idx == r_sel_need);
   assign w_any_zero  = |w_zero;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_NORMAL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A level found at zero outranks a test toggle landing in the same cycle
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_NORMAL: begin
            if (w_any_zero) begin
               w_state_nxt = ST_DEAD;
            end else if (w_test_toggle) begin
               w_state_nxt = ST_TEST;
            end
         end
         ST_TEST: begin
            if (w_test_toggle) begin
               w_state_nxt = ST_NORMAL;
            end
         end
         ST_DEAD: begin
            w_state_nxt = ST_DEAD;
         end
         default: begin
            w_state_nxt = ST_NORMAL;
         end
      endcase
      if (w_pet_reset) begin
         w_state_nxt = ST_NORMAL;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || w_pet_reset) begin
         r_sel_need <= '0;
      end else if (w_hit && w_alive && (w_hit_idx != r_sel_need)) begin
         r_sel_need <= w_hit_idx;
      end
   end

   for (genvar g = 0; g < NUM_NEEDS; g++) begin : g_need
      logic [7:0]         r_timer;
      logic [LEVEL_W-1:0] r_level;
      logic               w_act;
      logic               w_decay;

      assign w_act   = w_press_sel & (r_sel_need == SEL_W'(g));
      assign w_decay = w_normal & w_sec_tick & (r_timer == (DECAY_SEC[g*8 +: 8] - 8'd1));

      always_ff @(posedge clk) begin
         if (!rst_n || w_pet_reset) begin
            r_timer <= '0;
         end else if (w_normal && w_sec_tick) begin
            r_timer <= w_decay ? 8'd0 : r_timer + 8'd1;
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n || w_pet_reset) begin
            r_level <= L_INIT;
         end else if (w_test) begin
            if (w_act) begin
               r_level <= (r_level == L_ONE) ? L_MAX : L_ONE;
            end
         end else if (w_act && !w_decay) begin
            if (r_level < L_MAX) begin
               r_level <= r_level + L_ONE;
            end
         end else if (w_decay && !w_act) begin
            if (r_level != '0) begin
               r_level <= r_level - L_ONE;
            end
         end
      end

      assign w_zero[g]                       = (r_level == '0);
      assign w_level_arr[g]                  = r_level;
      assign w_levels[g*LEVEL_W +: LEVEL_W]  = r_level;
   end

   assign w_sel_level = w_level_arr[r_sel_need];

   assign bus.sel_need  = r_sel_need;
   assign bus.sel_level = w_sel_level;
   assign bus.levels    = w_levels;
   assign bus.happy     = (w_sel_level >= L_HAPPY);
   assign bus.seg7      = seg7_encode(8'(w_sel_level));
   assign bus.test_mode = w_test;
   assign bus.dead      = (r_state == ST_DEAD);
   assign bus.sec_tick  = w_sec_tick;

endmodule
